// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and common widths.
// Used by both the write-side and read-side pointer logic.
package fifo_pkg;

    localparam int DROP_CNT_W = 16;
    // Widest pointer the helpers handle; callers zero-extend narrower
    // pointers into it and truncate the result back to their width.
    localparam int PTR_MAX_W  = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the low bits of the result intact,
    // so this is correct for any width up to PTR_MAX_W.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of parameterised width.
// Reusable for either side of the FIFO.
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic [PTR_MAX_W-1:0] w_bin_ext;

    // Convert in the wide helper, then keep only the bits we own.
    assign w_bin_ext = gray2bin(PTR_MAX_W'(i_gray));
    assign o_bin     = w_bin_ext[WIDTH-1:0];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Async FIFO write-side pointer controller (write clock domain).
// Keeps binary/Gray write pointers, full/almost-full/free-count status
// against the synchronised Gray read pointer, and a sticky overflow flag.
// Optional WR_PTR_DROP_CNT_EN adds a saturating rejected-write counter.
module wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_LEN = 5
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [ADDR_LEN:0]     sync_rd_ptr,
    input  logic [ADDR_LEN:0]     afull_thresh,
    input  logic                  ovf_clr,
    output logic [ADDR_LEN-1:0]   wr_addr,
    output logic [ADDR_LEN:0]     wr_ptr,
    output logic                  wr_full,
    output logic                  wr_afull,
    output logic [ADDR_LEN:0]     wr_free,
`ifdef WR_PTR_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] wr_drop_cnt,
`endif
    output logic                  wr_ovf
);

    localparam int DEPTH = 1 << ADDR_LEN;
    localparam int PW    = ADDR_LEN + 1;

    logic [PW-1:0]        r_bin;
    logic [PW-1:0]        r_gray;
    logic [PW-1:0]        r_free;
    logic                 r_full;
    logic                 r_afull;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_drop;
    logic [PW-1:0]        w_bin_next;
    logic [PTR_MAX_W-1:0] w_gray_ext;
    logic [PW-1:0]        w_gray_next;
    logic [PW-1:0]        w_rd_bin;
    logic [PW-1:0]        w_used_next;
    logic [PW-1:0]        w_free_next;
    logic [PW-1:0]        w_full_cmp;

    gray_to_bin #(.WIDTH(PW)) u_rd_g2b (
        .i_gray (sync_rd_ptr),
        .o_bin  (w_rd_bin)
    );

    // Gate on the registered full flag so status and accept never disagree.
    assign w_accept    = wr_en & ~r_full;
    assign w_drop      = wr_en & r_full;
    assign w_bin_next  = r_bin + PW'(w_accept);
    assign w_gray_ext  = bin2gray(PTR_MAX_W'(w_bin_next));
    assign w_gray_next = w_gray_ext[PW-1:0];

    // Level math wraps naturally in PW bits; the extra MSB keeps
    // full (used == DEPTH) distinct from empty (used == 0).
    assign w_used_next = w_bin_next - w_rd_bin;
    assign w_free_next = PW'(DEPTH) - w_used_next;

    // In Gray code, "exactly DEPTH ahead" means the top two bits inverted.
    assign w_full_cmp  = {~sync_rd_ptr[ADDR_LEN:ADDR_LEN-1], sync_rd_ptr[ADDR_LEN-2:0]};

    // Pointer and status registers; status reflects the post-write pointer.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_free  <= PW'(DEPTH);
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_full  <= (w_gray_next == w_full_cmp);
            r_afull <= (w_free_next <= afull_thresh);
            r_free  <= w_free_next;
        end
    end

    // Sticky overflow: a rejected write wins over a clear in the same cycle.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef WR_PTR_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Saturating rejected-write count; a drop during clear restarts at 1.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_drop_cnt <= DROP_CNT_W'(1);
            end else if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            r_drop_cnt <= '0;
        end
    end

    assign wr_drop_cnt = r_drop_cnt;
`endif

    assign wr_addr  = r_bin[ADDR_LEN-1:0];
    assign wr_ptr   = r_gray;
    assign wr_full  = r_full;
    assign wr_afull = r_afull;
    assign wr_free  = r_free;
    assign wr_ovf   = r_ovf;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Directed bench for wr_ptr_ctrl (ADDR_LEN=3, DEPTH=8). Stimulus pushes the
// hand-derived post-edge state into a queue; a negedge monitor pops and checks.
module tb_wr_ptr_ctrl;

    typedef struct {
        logic [3:0]  bin;
        logic [3:0]  free;
        logic        full;
        logic        afull;
        logic        ovf;
        logic [15:0] drop;
    } exp_t;

    logic        clk;
    logic        wr_rst;
    logic        wr_en;
    logic [3:0]  sync_rd_ptr;
    logic [3:0]  afull_thresh;
    logic        ovf_clr;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_ptr;
    logic        wr_full;
    logic        wr_afull;
    logic [3:0]  wr_free;
    logic        wr_ovf;
`ifdef WR_PTR_DROP_CNT_EN
    logic [15:0] wr_drop_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    wr_ptr_ctrl #(.ADDR_LEN(3)) dut (
        .wr_clk       (clk),
        .wr_rst       (wr_rst),
        .wr_en        (wr_en),
        .sync_rd_ptr  (sync_rd_ptr),
        .afull_thresh (afull_thresh),
        .ovf_clr      (ovf_clr),
        .wr_addr      (wr_addr),
        .wr_ptr       (wr_ptr),
        .wr_full      (wr_full),
        .wr_afull     (wr_afull),
        .wr_free      (wr_free),
`ifdef WR_PTR_DROP_CNT_EN
        .wr_drop_cnt  (wr_drop_cnt),
`endif
        .wr_ovf       (wr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input int bin, input int free, input bit full,
                                input bit afull, input bit ovf, input int drop);
        exp_t e;
        e.bin   = 4'(bin);
        e.free  = 4'(free);
        e.full  = full;
        e.afull = afull;
        e.ovf   = ovf;
        e.drop  = 16'(drop);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registered, so every negedge presents one result.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("wr_ptr",   32'(wr_ptr),   32'(gray4(e.bin)));
            chk("wr_addr",  32'(wr_addr),  32'(e.bin[2:0]));
            chk("wr_free",  32'(wr_free),  32'(e.free));
            chk("wr_full",  32'(wr_full),  32'(e.full));
            chk("wr_afull", 32'(wr_afull), 32'(e.afull));
            chk("wr_ovf",   32'(wr_ovf),   32'(e.ovf));
`ifdef WR_PTR_DROP_CNT_EN
            chk("wr_drop_cnt", 32'(wr_drop_cnt), 32'(e.drop));
`endif
        end
    end

    // Drive one cycle's inputs, then queue what the edge must produce.
    task automatic step(input logic en, input logic rst, input logic clr,
                        input logic [3:0] rd, input logic [3:0] thr, input exp_t e);
        @(negedge clk);
        wr_en        = en;
        wr_rst       = rst;
        ovf_clr      = clr;
        sync_rd_ptr  = rd;
        afull_thresh = thr;
        @(posedge clk);
        q.push_back(e);
    endtask

    initial begin
        logic [3:0] b;
        wr_rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0;
        sync_rd_ptr = 4'd0; afull_thresh = 4'd2;

        // Reset holds over an active write request
        step(1, 1, 0, 4'd0, 4'd2, mk(0, 8, 0, 0, 0, 0));
        step(1, 1, 0, 4'd0, 4'd2, mk(0, 8, 0, 0, 0, 0));

        // Fill 8 entries: afull once free<=2, full after the 8th
        for (int k = 1; k <= 8; k++)
            step(1, 0, 0, 4'd0, 4'd2, mk(k, 8 - k, k == 8, (8 - k) <= 2, 0, 0));

        // Writes while full are dropped and flagged
        for (int k = 1; k <= 3; k++)
            step(1, 0, 0, 4'd0, 4'd2, mk(8, 0, 1, 1, 1, k));
        step(1, 0, 1, 4'd0, 4'd2, mk(8, 0, 1, 1, 1, 1));   // set wins over clear
        step(0, 0, 1, 4'd0, 4'd2, mk(8, 0, 1, 1, 0, 0));   // clear alone

        // Reader advances to bin 3: free 3, then one write leaves 2
        step(0, 0, 0, 4'b0010, 4'd2, mk(8, 3, 0, 0, 0, 0));
        step(1, 0, 0, 4'b0010, 4'd2, mk(9, 2, 0, 1, 0, 0));

        // Reader trails by 4 entries; stream across the pointer wrap
        step(0, 0, 0, gray4(4'd5), 4'd2, mk(9, 4, 0, 0, 0, 0));
        for (int j = 1; j <= 25; j++) begin
            b = 4'(9 + j);
            step(1, 0, 0, gray4(b - 4'd4), 4'd2, mk(b, 4, 0, 0, 0, 0));
        end

        // Reset mid-burst drops the write, no overflow
        step(1, 1, 0, 4'd0, 4'd2, mk(0, 8, 0, 0, 0, 0));

        // Threshold corners: >=DEPTH asserts afull at once, 0 tracks full
        step(0, 0, 0, 4'd0, 4'd8, mk(0, 8, 0, 1, 0, 0));
        step(0, 0, 0, 4'd0, 4'd0, mk(0, 8, 0, 0, 0, 0));

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
